// File: rtl/prog_tick_timer.sv
// -----------------------------------------------------------------------------
// prog_tick_timer
//   Programmable tick timer with a prescaler. After an accepted start, the
//   timer counts `period` prescaled steps (one step every prescale+1 clocks)
//   and emits a one-cycle tick when the period expires. In periodic mode it
//   reloads and keeps running; in one-shot mode it returns to IDLE.
//
// Ports
//   clk       in   rising-edge system clock
//   resetN    in   asynchronous, active-low reset
//   start     in   load configuration and begin counting (one-cycle request)
//   stop      in   abort counting (one-cycle request, highest priority)
//   mode      in   0 = periodic, 1 = one-shot
//   period    in   N-bit number of prescaled steps per tick
//   prescale  in   P-bit divider, one step every prescale+1 clocks
//   tick      out  registered one-cycle pulse at each period expiry
//   busy      out  high while in RUN
//   count     out  remaining step count, 0 in IDLE
//   err       out  registered one-cycle pulse when start is rejected
// -----------------------------------------------------------------------------
module prog_tick_timer #(
  parameter int N = 16,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] period,
  input  logic [P-1:0] prescale,
  output logic         tick,
  output logic         busy,
  output logic [N-1:0] count,
  output logic         err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] PSC_ZERO = {P{1'b0}};
  localparam logic [P-1:0] PSC_ONE  = {{(P-1){1'b0}}, 1'b1};

  state_e       state_q,    state_d;
  logic [N-1:0] count_q,    count_d;
  logic [P-1:0] psc_q,      psc_d;
  logic [N-1:0] period_q,   period_d;
  logic [P-1:0] prescale_q, prescale_d;
  logic         mode_q,     mode_d;
  logic         tick_q,     tick_d;
  logic         err_q,      err_d;
  logic         start_ok;

  // Next-state logic: stop beats start, start beats expiry, then normal counting
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    psc_d      = psc_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    err_d      = 1'b0;
    start_ok   = start & ~stop & (period != CNT_ZERO);

    if (stop) begin
      state_d = IDLE;
      count_d = CNT_ZERO;
      psc_d   = PSC_ZERO;
    end else if (start_ok) begin
      // Restart from the freshly sampled configuration; an expiry on this
      // same edge is deliberately dropped.
      state_d    = RUN;
      period_d   = period;
      prescale_d = prescale;
      mode_d     = mode;
      count_d    = period - CNT_ONE;
      psc_d      = prescale;
    end else begin
      // A start that reaches here had period == 0: flag it, keep running.
      if (start) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          count_d = CNT_ZERO;
          psc_d   = PSC_ZERO;
        end
        RUN: begin
          if (psc_q == PSC_ZERO) begin
            // Prescaler step
            psc_d = prescale_q;
            if (count_q == CNT_ZERO) begin
              tick_d = 1'b1;
              if (mode_q) begin
                state_d = IDLE;
                count_d = CNT_ZERO;
                psc_d   = PSC_ZERO;
              end else begin
                // period_q is never 0 once latched, so this cannot wrap
                count_d = period_q - CNT_ONE;
              end
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end else begin
            psc_d = psc_q - PSC_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = CNT_ZERO;
          psc_d   = PSC_ZERO;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      count_q    <= CNT_ZERO;
      psc_q      <= PSC_ZERO;
      period_q   <= CNT_ZERO;
      prescale_q <= PSC_ZERO;
      mode_q     <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign tick  = tick_q;
  assign busy  = (state_q == RUN);
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_prog_tick_timer.sv
// -----------------------------------------------------------------------------
// tb_prog_tick_timer
//   Directed bench for prog_tick_timer built with N=4, P=2 so that the
//   maximum period (15) and maximum prescale (3) are exercised.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. "Cycle j" below is the j-th falling edge after the start edge k,
//   i.e. the value registered on edge k+j-1.
// -----------------------------------------------------------------------------
module tb_prog_tick_timer;

  logic       clk;
  logic       resetN;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] period;
  logic [1:0] prescale;
  logic       tick;
  logic       busy;
  logic [3:0] count;
  logic       err;

  int n_checks;
  int n_pass;

  prog_tick_timer #(.N(4), .P(2)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .prescale (prescale),
    .tick     (tick),
    .busy     (busy),
    .count    (count),
    .err      (err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a start request on exactly one rising edge (edge k)
  task automatic pulse_start(input logic m, input logic [3:0] per, input logic [1:0] pre);
    @(negedge clk);
    start    = 1'b1;
    mode     = m;
    period   = per;
    prescale = pre;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Present stop on exactly one rising edge
  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    n_checks++;
    if ({tick, busy, count, err} !== 7'b0) begin
      $display("FAIL reset: tick/busy/count/err got %b, want 0000000", {tick, busy, count, err});
    end else n_pass++;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tick, busy, count, err} !== 7'b0) begin
      $display("FAIL reset_release: got %b, want 0000000", {tick, busy, count, err});
    end else n_pass++;
  endtask

  // period=1, prescale=0: tick from cycle 2 onward, every cycle
  task automatic test_periodic_fast();
    pulse_start(1'b0, 4'd1, 2'd0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      n_checks++;
      if ({tick, busy, count} !== {(j >= 2), 1'b1, 4'd0}) begin
        $display("FAIL periodic_fast j=%0d: tick/busy/count got %b %b %0d, want %b 1 0",
                 j, tick, busy, count, (j >= 2));
      end else n_pass++;
    end
    pulse_stop();
    @(negedge clk);
    n_checks++;
    if ({tick, busy, count} !== {1'b0, 1'b0, 4'd0}) begin
      $display("FAIL periodic_fast_stop: got %b %b %0d, want 0 0 0", tick, busy, count);
    end else n_pass++;
  endtask

  // period=5, prescale=3: ticks at 21, 41; stop on the third expiry edge (k+60)
  task automatic test_periodic_slow();
    logic [3:0] exp_cnt;
    logic       exp_tick;
    logic       exp_busy;
    pulse_start(1'b0, 4'd5, 2'd3);
    for (int j = 1; j <= 63; j++) begin
      @(negedge clk);
      if (j <= 60) begin
        exp_cnt  = 4'(4 - (((j - 1) / 4) % 5));
        exp_tick = (j == 21) || (j == 41);
        exp_busy = 1'b1;
      end else begin
        exp_cnt  = 4'd0;
        exp_tick = 1'b0;
        exp_busy = 1'b0;
      end
      n_checks++;
      if ({tick, busy, count} !== {exp_tick, exp_busy, exp_cnt}) begin
        $display("FAIL periodic_slow j=%0d: tick/busy/count got %b %b %0d, want %b %b %0d",
                 j, tick, busy, count, exp_tick, exp_busy, exp_cnt);
      end else n_pass++;
      stop = (j == 60);
    end
    stop = 1'b0;
  endtask

  // one-shot, period=3, prescale=1: single tick at 7, busy low from 7
  task automatic test_oneshot();
    logic [3:0] exp_cnt;
    pulse_start(1'b1, 4'd3, 2'd1);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      exp_cnt = (j <= 6) ? 4'(2 - ((j - 1) / 2)) : 4'd0;
      n_checks++;
      if ({tick, busy, count} !== {(j == 7), (j <= 6), exp_cnt}) begin
        $display("FAIL oneshot j=%0d: tick/busy/count got %b %b %0d, want %b %b %0d",
                 j, tick, busy, count, (j == 7), (j <= 6), exp_cnt);
      end else n_pass++;
    end
  endtask

  // period=0 start rejected, both from IDLE and while running
  task automatic test_err();
    pulse_start(1'b0, 4'd0, 2'd2);
    @(negedge clk);
    n_checks++;
    if ({err, busy, count} !== {1'b1, 1'b0, 4'd0}) begin
      $display("FAIL err_idle: err/busy/count got %b %b %0d, want 1 0 0", err, busy, count);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      $display("FAIL err_pulse_width: err got %b, want 0", err);
    end else n_pass++;

    pulse_start(1'b0, 4'd5, 2'd3);
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      if (j == 3) begin
        n_checks++;
        if ({err, busy, count} !== {1'b1, 1'b1, 4'd4}) begin
          $display("FAIL err_run: err/busy/count got %b %b %0d, want 1 1 4", err, busy, count);
        end else n_pass++;
      end else if (j >= 20) begin
        n_checks++;
        if ({tick, err} !== {(j == 21), 1'b0}) begin
          $display("FAIL err_run_timing j=%0d: tick/err got %b %b, want %b 0", j, tick, err, (j == 21));
        end else n_pass++;
      end
      start  = (j == 2);
      period = (j == 2) ? 4'd0 : 4'd5;
    end
    start = 1'b0;
    pulse_stop();
  endtask

  // Restart on an expiry edge: no tick from the interrupted period
  task automatic test_restart();
    pulse_start(1'b0, 4'd2, 2'd0);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 3) begin
        n_checks++;
        if (tick !== 1'b1) begin
          $display("FAIL restart_first_tick: tick got %b, want 1", tick);
        end else n_pass++;
      end else if (j >= 5) begin
        n_checks++;
        if ({tick, busy} !== {(j == 8), 1'b1}) begin
          $display("FAIL restart j=%0d: tick/busy got %b %b, want %b 1", j, tick, busy, (j == 8));
        end else n_pass++;
        if (j == 5) begin
          n_checks++;
          if (count !== 4'd2) begin
            $display("FAIL restart_count: count got %0d, want 2", count);
          end else n_pass++;
        end
      end
      start  = (j == 4);
      period = (j == 4) ? 4'd3 : 4'd2;
    end
    start = 1'b0;
  endtask

  // start and stop together while running: stop wins
  task automatic test_start_stop();
    @(negedge clk);
    start  = 1'b1;
    stop   = 1'b1;
    period = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tick, busy, count, err} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
      $display("FAIL start_stop: tick/busy/count/err got %b %b %0d %b, want 0 0 0 0",
               tick, busy, count, err);
    end else n_pass++;
  endtask

  // Maximum period and prescale: tick at 15*4+1 = 61
  task automatic test_max();
    pulse_start(1'b0, 4'd15, 2'd3);
    for (int j = 1; j <= 62; j++) begin
      @(negedge clk);
      if (j == 1 || j == 60 || j == 61 || j == 62) begin
        n_checks++;
        if ({tick, count} !== {(j == 61), (j == 1 || j >= 61) ? 4'd14 : 4'd0}) begin
          $display("FAIL max j=%0d: tick/count got %b %0d", j, tick, count);
        end else n_pass++;
      end
    end
    pulse_stop();
  endtask

  // Asynchronous reset in the middle of a run
  task automatic test_reset_midrun();
    pulse_start(1'b0, 4'd15, 2'd0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
    end
    n_checks++;
    if ({busy, count} !== {1'b1, 4'd11}) begin
      $display("FAIL midrun_pre: busy/count got %b %0d, want 1 11", busy, count);
    end else n_pass++;
    #2;
    resetN = 1'b0;
    #1;
    n_checks++;
    if ({tick, busy, count, err} !== 7'b0) begin
      $display("FAIL midrun_reset: got %b, want 0000000", {tick, busy, count, err});
    end else n_pass++;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      n_checks++;
      if ({tick, busy, count} !== {1'b0, 1'b0, 4'd0}) begin
        $display("FAIL midrun_after j=%0d: tick/busy/count got %b %b %0d, want 0 0 0",
                 j, tick, busy, count);
      end else n_pass++;
    end
  endtask

  // Test sequence
  initial begin
    n_checks = 0;
    n_pass   = 0;
    start    = 1'b0;
    stop     = 1'b0;
    mode     = 1'b0;
    period   = 4'd0;
    prescale = 2'd0;
    resetN   = 1'b0;
    test_reset();
    test_periodic_fast();
    test_periodic_slow();
    test_oneshot();
    test_err();
    test_restart();
    test_start_stop();
    test_max();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
